// File: rtl/baccarat_fsm.sv
// baccarat_fsm: baccarat dealing controller sequencing card loads, third-card rules and result lamps.
module baccarat_fsm (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);
  typedef enum logic [3:0] {
    IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, DRAW_P3, EVAL_D, DRAW_D3, DONE
  } state_t;
  state_t state_q, state_d;
  logic [3:0] v;
  logic d_draw;
  always_comb v = (pcard3 >= 4'd1 && pcard3 <= 4'd9) ? pcard3 : 4'd0;
  // dealer third-card rule, keyed on dealer score and player third-card value
  always_comb
    d_draw = (dscore <= 4'd2) ? 1'b1 :
             (dscore == 4'd3) ? (v != 4'd8) :
             (dscore == 4'd4) ? (v >= 4'd2 && v <= 4'd7) :
             (dscore == 4'd5) ? (v >= 4'd4 && v <= 4'd7) :
             (dscore == 4'd6) ? (v >= 4'd6 && v <= 4'd7) : 1'b0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = DEAL_P1;
      DEAL_P1: state_d = DEAL_D1;
      DEAL_D1: state_d = DEAL_P2;
      DEAL_P2: state_d = DEAL_D2;
      DEAL_D2: state_d = EVAL;
      EVAL:    state_d = (pscore >= 4'd8 || dscore >= 4'd8) ? DONE :
                         (pscore <= 4'd5) ? DRAW_P3 :
                         (dscore <= 4'd5) ? DRAW_D3 : DONE;
      DRAW_P3: state_d = EVAL_D;
      EVAL_D:  state_d = d_draw ? DRAW_D3 : DONE;
      DRAW_D3: state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // load enables are registered from the next state so they stay glitch-free Moore outputs
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      load_pcard1 <= 1'b0;
      load_pcard2 <= 1'b0;
      load_pcard3 <= 1'b0;
      load_dcard1 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_dcard3 <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_pcard1 <= state_d == DEAL_P1;
      load_dcard1 <= state_d == DEAL_D1;
      load_pcard2 <= state_d == DEAL_P2;
      load_dcard2 <= state_d == DEAL_D2;
      load_pcard3 <= state_d == DRAW_P3;
      load_dcard3 <= state_d == DRAW_D3;
    end
  end
  // lamps use live scores so the final drawn card counts
  assign player_win_light = (state_q == DONE) && (pscore >= dscore);
  assign dealer_win_light = (state_q == DONE) && (dscore >= pscore);
endmodule

// File: tb/tb_baccarat_fsm.sv
// tb_baccarat_fsm: scoreboard bench for baccarat_fsm; vectors are {pl1,dl1,pl2,dl2,pl3,dl3,pwin,dwin}.
module tb_baccarat_fsm;
  logic slow_clock = 1'b0;
  logic resetb = 1'b0;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3;
  logic player_win_light, dealer_win_light;
  logic [7:0] sb[$];
  logic [7:0] exp_v;
  int checks = 0, errors = 0;

  baccarat_fsm dut (
    .slow_clock(slow_clock), .resetb(resetb), .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light)
  );

  always #5 slow_clock = ~slow_clock;

  function automatic logic [7:0] obs();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3,
            player_win_light, dealer_win_light};
  endfunction

  // dealer draw masks indexed by card value 0..9, one per dealer score 0..7
  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] c3);
    logic [9:0] mask;
    int val;
    val = (c3 >= 1 && c3 <= 9) ? int'(c3) : 0;
    case (ds)
      4'd0, 4'd1, 4'd2: mask = 10'b11_1111_1111;
      4'd3:             mask = 10'b10_1111_1111;
      4'd4:             mask = 10'b00_1111_1100;
      4'd5:             mask = 10'b00_1111_0000;
      4'd6:             mask = 10'b00_1100_0000;
      default:          mask = 10'b00_0000_0000;
    endcase
    return mask[val];
  endfunction

  task automatic expect_game(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] c3);
    sb.push_back(8'h80); sb.push_back(8'h40); sb.push_back(8'h20); sb.push_back(8'h10);
    sb.push_back(8'h00);
    if (!(ps >= 8 || ds >= 8)) begin
      if (ps <= 5) begin
        sb.push_back(8'h08);
        sb.push_back(8'h00);
        if (dealer_draws(ds, c3)) sb.push_back(8'h04);
      end else if (ds <= 5) sb.push_back(8'h04);
    end
    sb.push_back({6'b0, ps >= ds, ds >= ps});
    sb.push_back({6'b0, ps >= ds, ds >= ps});
  endtask

  task automatic start_game(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] c3);
    @(negedge slow_clock);
    resetb = 1'b0;
    pscore = ps; dscore = ds; pcard3 = c3;
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs() !== 8'h00) begin errors++; $display("FAIL reset_async got=%h exp=00", obs()); end
    repeat (3) @(negedge slow_clock);
    checks++;
    if (obs() !== 8'h00) begin errors++; $display("FAIL reset_hold got=%h exp=00", obs()); end
  endtask

  task automatic test_natural();
    start_game(4'd8, 4'd3, 4'd0);
    expect_game(4'd8, 4'd3, 4'd0);
    while (sb.size() > 0) begin
      @(negedge slow_clock);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL natural got=%h exp=%h", obs(), exp_v); end
    end
  endtask

  task automatic test_player_draw();
    start_game(4'd4, 4'd6, 4'd8);
    expect_game(4'd4, 4'd6, 4'd8);
    while (sb.size() > 0) begin
      @(negedge slow_clock);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL player_draw got=%h exp=%h", obs(), exp_v); end
    end
    pscore = 4'd2;
    sb.push_back(8'h01);
    @(negedge slow_clock);
    exp_v = sb.pop_front();
    checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL player_draw_lights got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_face_card();
    logic [3:0] cards[2] = '{4'd8, 4'd13};
    foreach (cards[i]) begin
      start_game(4'd3, 4'd3, cards[i]);
      expect_game(4'd3, 4'd3, cards[i]);
      while (sb.size() > 0) begin
        @(negedge slow_clock);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v) begin
          errors++; $display("FAIL face_card c3=%0d got=%h exp=%h", cards[i], obs(), exp_v);
        end
      end
    end
  endtask

  task automatic test_tie();
    start_game(4'd6, 4'd5, 4'd0);
    expect_game(4'd6, 4'd5, 4'd0);
    while (sb.size() > 0) begin
      @(negedge slow_clock);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL stand got=%h exp=%h", obs(), exp_v); end
    end
    dscore = 4'd6;
    sb.push_back(8'h03);
    @(negedge slow_clock);
    exp_v = sb.pop_front();
    checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL tie_lights got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_score_edges();
    logic [3:0] ps[5] = '{4'd12, 4'd0, 4'd7, 4'd6, 4'd5};
    logic [3:0] ds[5] = '{4'd0, 4'd15, 4'd7, 4'd6, 4'd7};
    foreach (ps[i]) begin
      start_game(ps[i], ds[i], 4'd1);
      expect_game(ps[i], ds[i], 4'd1);
      while (sb.size() > 0) begin
        @(negedge slow_clock);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v) begin
          errors++; $display("FAIL score_edge ps=%0d ds=%0d got=%h exp=%h", ps[i], ds[i], obs(), exp_v);
        end
      end
    end
  endtask

  task automatic test_dealer_table();
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 14; c++) begin
        start_game(4'd0, 4'(d), 4'(c));
        expect_game(4'd0, 4'(d), 4'(c));
        while (sb.size() > 0) begin
          @(negedge slow_clock);
          exp_v = sb.pop_front();
          checks++;
          if (obs() !== exp_v) begin
            errors++; $display("FAIL dealer_table ds=%0d c3=%0d got=%h exp=%h", d, c, obs(), exp_v);
          end
        end
      end
  endtask

  task automatic test_reset_midgame();
    start_game(4'd4, 4'd4, 4'd2);
    sb.push_back(8'h80); sb.push_back(8'h40); sb.push_back(8'h20);
    while (sb.size() > 0) begin
      @(negedge slow_clock);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL midgame_deal got=%h exp=%h", obs(), exp_v); end
    end
    #2 resetb = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'h00) begin errors++; $display("FAIL midgame_reset got=%h exp=00", obs()); end
    @(negedge slow_clock);
    resetb = 1'b1;
    #1;
    checks++;
    if (obs() !== 8'h00) begin errors++; $display("FAIL midgame_idle got=%h exp=00", obs()); end
    sb.push_back(8'h80); sb.push_back(8'h40);
    while (sb.size() > 0) begin
      @(negedge slow_clock);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL midgame_restart got=%h exp=%h", obs(), exp_v); end
    end
  endtask

  task automatic test_reset_in_done();
    start_game(4'd9, 4'd9, 4'd0);
    expect_game(4'd9, 4'd9, 4'd0);
    while (sb.size() > 0) begin
      @(negedge slow_clock);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL done_game got=%h exp=%h", obs(), exp_v); end
    end
    #2 resetb = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'h00) begin errors++; $display("FAIL done_reset got=%h exp=00", obs()); end
    resetb = 1'b1;
  endtask

  initial begin
    test_reset();
    test_natural();
    test_player_draw();
    test_face_card();
    test_tie();
    test_score_edges();
    test_dealer_table();
    test_reset_midgame();
    test_reset_in_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
